// File: rtl/entry_checker.sv
// Parking gate entry checker: registered gate grant and full flag, plus
// saturating counts of granted and denied entry requests.
module entry_checker (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        entry,
  input  logic [7:0]  parking_capacity,
  output logic        enable,
  output logic        full,
  output logic [15:0] granted_count,
  output logic [15:0] denied_count
);

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  logic        r_entry_q;
  logic        r_enable;
  logic        r_full;
  logic [15:0] r_granted;
  logic [15:0] r_denied;

  logic w_space_free;
  logic w_grant;
  logic w_request_edge;

  assign w_space_free   = (parking_capacity != 8'd0);
  assign w_grant        = entry && w_space_free;
  // A request is counted only on the cycle entry rises, so a car parked at
  // the gate is counted once no matter how long it waits.
  assign w_request_edge = entry && !r_entry_q;

  // NOTE: non-blocking assignments keep every register reading the
  // pre-edge value of the others, which is what a flip-flop does.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_entry_q <= 1'b0;
      r_enable  <= 1'b0;
      r_full    <= 1'b0;
      r_granted <= 16'd0;
      r_denied  <= 16'd0;
    end else begin
      r_entry_q <= entry;
      r_enable  <= w_grant;
      r_full    <= !w_space_free;
      if (w_request_edge && w_space_free && (r_granted != COUNT_MAX))
        r_granted <= r_granted + 16'd1;
      if (w_request_edge && !w_space_free && (r_denied != COUNT_MAX))
        r_denied <= r_denied + 16'd1;
    end
  end

  assign enable        = r_enable;
  assign full          = r_full;
  assign granted_count = r_granted;
  assign denied_count  = r_denied;

endmodule

// File: tb/tb_entry_checker.sv
// Self-checking bench for entry_checker: a behavioural model compared every
// cycle, plus literal expectations at the key points of the directed sequence.
module tb_entry_checker;

  logic        clk;
  logic        rst_n;
  logic        entry;
  logic [7:0]  parking_capacity;
  logic        enable;
  logic        full;
  logic [15:0] granted_count;
  logic [15:0] denied_count;

  int checks   = 0;
  int failures = 0;
  bit checking = 0;

  // Behavioural model state (plain integers, saturation by clamp).
  bit m_enable, m_full, m_prev_entry;
  int m_granted, m_denied;

  entry_checker dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .entry            (entry),
    .parking_capacity (parking_capacity),
    .enable           (enable),
    .full             (full),
    .granted_count    (granted_count),
    .denied_count     (denied_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what each output must be after an edge, from the rules alone.
  always @(posedge clk) begin
    if (rst_n !== 1'b1) begin
      m_enable = 0; m_full = 0; m_granted = 0; m_denied = 0; m_prev_entry = 0;
    end else begin
      m_enable = entry && (parking_capacity != 0);
      m_full   = (parking_capacity == 0);
      if (entry && !m_prev_entry) begin
        if (parking_capacity != 0) m_granted = (m_granted + 1 > 65535) ? 65535 : m_granted + 1;
        else                       m_denied  = (m_denied  + 1 > 65535) ? 65535 : m_denied  + 1;
      end
      m_prev_entry = entry;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("model_enable",  {31'd0, enable}, {31'd0, m_enable});
      check("model_full",    {31'd0, full},   {31'd0, m_full});
      check("model_granted", {16'd0, granted_count}, m_granted[31:0]);
      check("model_denied",  {16'd0, denied_count},  m_denied[31:0]);
    end
  end

  // Inputs change away from both edges; returns just after the next rising edge.
  task automatic cycle(input logic r, input logic e, input logic [7:0] c);
    @(negedge clk);
    #2;
    rst_n = r; entry = e; parking_capacity = c;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string name, input logic en, input logic fl,
                            input logic [15:0] g, input logic [15:0] d);
    check({name, "_enable"},  {31'd0, enable}, {31'd0, en});
    check({name, "_full"},    {31'd0, full},   {31'd0, fl});
    check({name, "_granted"}, {16'd0, granted_count}, {16'd0, g});
    check({name, "_denied"},  {16'd0, denied_count},  {16'd0, d});
  endtask

  logic [7:0] pat_cap [8] = '{8'd0, 8'd1, 8'd1, 8'd0, 8'h7F, 8'h7F, 8'd0, 8'h80};
  logic       pat_ent [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0; entry = 1'b0; parking_capacity = 8'd0;
    cycle(1'b0, 1'b0, 8'd0);
    checking = 1;
    cycle(1'b0, 1'b1, 8'd9);
    expect_all("reset", 1'b0, 1'b0, 16'd0, 16'd0);

    cycle(1'b1, 1'b1, 8'b10001000);
    expect_all("grant_high_cap", 1'b1, 1'b0, 16'd1, 16'd0);
    cycle(1'b1, 1'b1, 8'b00101000);
    expect_all("held_cap_change", 1'b1, 1'b0, 16'd1, 16'd0);
    cycle(1'b1, 1'b1, 8'h00);
    expect_all("held_cap_zero", 1'b0, 1'b1, 16'd1, 16'd0);
    cycle(1'b1, 1'b0, 8'b10001000);
    expect_all("no_entry", 1'b0, 1'b0, 16'd1, 16'd0);
    cycle(1'b1, 1'b1, 8'h00);
    expect_all("deny_edge", 1'b0, 1'b1, 16'd1, 16'd1);
    cycle(1'b1, 1'b1, 8'd3);
    expect_all("held_zero_to_free", 1'b1, 1'b0, 16'd1, 16'd1);
    cycle(1'b1, 1'b0, 8'd0);
    expect_all("idle_full", 1'b0, 1'b1, 16'd1, 16'd1);

    for (int i = 0; i < 8; i++) cycle(1'b1, pat_ent[i], pat_cap[i]);
    // Pattern: edges at i=0 (deny), i=2 (grant), i=5 (grant), i=7 (grant).
    expect_all("pattern", 1'b1, 1'b0, 16'd4, 16'd2);

    cycle(1'b1, 1'b0, 8'd1);
    force dut.r_granted = 16'hFFFE;
    #1;
    release dut.r_granted;
    m_granted = 65534;
    cycle(1'b1, 1'b1, 8'd1);
    expect_all("sat_reach", 1'b1, 1'b0, 16'hFFFF, 16'd2);
    cycle(1'b1, 1'b0, 8'd1);
    cycle(1'b1, 1'b1, 8'd1);
    expect_all("sat_hold", 1'b1, 1'b0, 16'hFFFF, 16'd2);

    cycle(1'b0, 1'b1, 8'd1);
    expect_all("mid_reset", 1'b0, 1'b0, 16'd0, 16'd0);
    cycle(1'b1, 1'b1, 8'd1);
    expect_all("release_held_entry", 1'b1, 1'b0, 16'd1, 16'd0);
    cycle(1'b1, 1'b1, 8'd1);
    expect_all("release_no_recount", 1'b1, 1'b0, 16'd1, 16'd0);

    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/entry_checker.md
ENTRY_CHECKER -- requirements
Module: entry_checker

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 entry  input  1  SHALL be the vehicle entry request, level-sensitive, 1 = car waiting at gate.
REQ-005 parking_capacity  input  8  SHALL be the number of free spaces, unsigned, 0..255.
REQ-006 enable  output  1  SHALL be the gate-open grant, registered.
REQ-007 full  output  1  SHALL be the registered flag for "no free spaces".
REQ-008 granted_count  output  16  SHALL count granted entry requests, registered.
REQ-009 denied_count  output  16  SHALL count denied entry requests, registered.

Function
REQ-010 Grant condition SHALL be: grant = entry AND (parking_capacity != 0); any nonzero capacity value qualifies, including 8'h80 and above.
REQ-011 enable SHALL be loaded with grant on every rising clk edge while rst_n = 1, giving 1-cycle latency from inputs to enable.
REQ-012 enable SHALL be 0 whenever entry = 0, regardless of capacity.
REQ-013 enable SHALL be 0 whenever parking_capacity = 0, regardless of entry.
REQ-014 full SHALL be loaded with (parking_capacity == 0) on every rising edge, independent of entry.
REQ-015 The block SHALL register entry internally (entry_q) to detect a request rising edge: entry = 1 AND entry_q = 0.
REQ-016 On a request rising edge with capacity != 0, granted_count SHALL increment by 1.
REQ-017 On a request rising edge with capacity = 0, denied_count SHALL increment by 1.
REQ-018 A held entry level SHALL count once only, while enable still tracks capacity every cycle.
REQ-019 Both counters SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-020 An entry that stays high across a capacity change SHALL NOT cause a new count.
REQ-021 A capacity change while entry is held SHALL update enable on the next edge: nonzero->0 drops enable, 0->nonzero raises it.
REQ-022 The block SHALL contain no combinational path from inputs to outputs.

Reset
REQ-023 While rst_n = 0 at a rising edge, the block SHALL load enable = 0, full = 0, granted_count = 0, denied_count = 0 and entry_q = 0.
REQ-024 Reset SHALL take priority over all other updates, including counter increments in the same cycle.
REQ-025 Reset asserted mid-operation SHALL drop enable on that edge.
REQ-026 After reset release, if entry is already high it SHALL be treated as a rising edge on the first active cycle, because entry_q = 0.
REQ-027 Outputs SHALL NOT change asynchronously on rst_n.

Verification
REQ-028 entry=1, capacity=8'b10001000 -> enable=1 and full=0 one cycle later; granted_count=1.
REQ-029 Then, with entry held at 1, capacity=8'b00101000 -> enable stays 1; granted_count stays 1 (no new edge).
REQ-030 Then, with entry held at 1, capacity=8'h00 -> enable=0 and full=1 next cycle; denied_count unchanged.
REQ-031 entry=0, capacity=8'b10001000 -> enable=0 and full=0; then entry 0->1 with capacity=0 -> denied_count increments and enable=0.
REQ-032 Force granted_count to 16'hFFFE via 2 further grant pulses beyond it -> the count holds at 16'hFFFF.
REQ-033 rst_n=0 for one edge while enable=1 and counters are nonzero -> all outputs are 0 after that edge; with entry held high through release, granted_count=1 on the first active edge when capacity != 0.
